// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - writeback and decode-read bundle for the integer register file
interface regfile_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CW   = 32
);
    logic            we_i;
    logic [AW-1:0]   waddr_i;
    logic [XLEN-1:0] wdata_i;
    logic            re1_i;
    logic [AW-1:0]   raddr1_i;
    logic [XLEN-1:0] rdata1_o;
    logic            re2_i;
    logic [AW-1:0]   raddr2_i;
    logic [XLEN-1:0] rdata2_o;
    logic [CW-1:0]   wr_count_o;

    modport slave (
        input  we_i, waddr_i, wdata_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o, wr_count_o
    );

    modport master (
        output we_i, waddr_i, wdata_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o, wr_count_o
    );
endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - RISC-V integer register file, two bypassed read ports, committed-write counter
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    regfile_if.slave     bus
);
    logic [XLEN-1:0] r_regs [0:NREG-1];
    logic [CW-1:0]   r_wr_count;
    logic            w_commit;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;

    // x0 is never written, so it stays zero from reset onward
    assign w_commit = bus.we_i && (bus.waddr_i != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[bus.waddr_i] <= bus.wdata_i;
            r_wr_count          <= r_wr_count + CW'(1);
        end
    end

    // bypass lets decode see a retiring result in the same cycle
    always_comb begin
        w_rdata1 = '0;
        if (!rst_i && bus.re1_i && (bus.raddr1_i != '0)) begin
            if (bus.we_i && (bus.waddr_i == bus.raddr1_i)) begin
                w_rdata1 = bus.wdata_i;
            end else begin
                w_rdata1 = r_regs[bus.raddr1_i];
            end
        end
    end

    always_comb begin
        w_rdata2 = '0;
        if (!rst_i && bus.re2_i && (bus.raddr2_i != '0)) begin
            if (bus.we_i && (bus.waddr_i == bus.raddr2_i)) begin
                w_rdata2 = bus.wdata_i;
            end else begin
                w_rdata2 = r_regs[bus.raddr2_i];
            end
        end
    end

    assign bus.rdata1_o   = w_rdata1;
    assign bus.rdata2_o   = w_rdata2;
    assign bus.wr_count_o = r_wr_count;
endmodule
